// File: rtl/generador_prueba_spi.sv
// generador_prueba_spi
// Self-test sequencer for a memory-mapped SPI peripheral. It writes N_WORDS
// pattern words into the data bank, writes one instruction word to the
// control register, polls the busy bit, and then reads the data bank back.
// Each word read back is compared with the regenerated pattern. The results
// (mismatch count, first failing address, poll timeout) stay valid until
// the next accepted start.
module generador_prueba_spi #(
  parameter int          N_WORDS   = 256,
  parameter int          WAIT_CYC  = 10,
  parameter int          POLL_MAX  = 1000000,
  parameter logic [31:0] CTRL_WORD = 32'h0000_0FD1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        inicio_i,
  input  logic        abortar_i,
  input  logic [1:0]  modo_i,
  input  logic [31:0] semilla_i,
  input  logic [31:0] salida_i,
  output logic        wr_o,
  output logic        reg_sel_o,
  output logic [31:0] entrada_o,
  output logic [31:0] addr_o,
  output logic        ocupado_o,
  output logic        listo_o,
  output logic        timeout_o,
  output logic [15:0] cuenta_err_o,
  output logic [7:0]  dir_err_o
);

  localparam logic [2:0] IDLE                 = 3'd0;
  localparam logic [2:0] ESCRIBIR_DATOS       = 3'd1;
  localparam logic [2:0] ESCRIBIR_INSTRUCCION = 3'd2;
  localparam logic [2:0] ESPERAR              = 3'd3;
  localparam logic [2:0] LEER_DATOS           = 3'd4;
  localparam logic [2:0] FIN                  = 3'd5;

  // The slot counter runs 0..WAIT_CYC. The poll counter runs 0..POLL_MAX-1.
  // One spare bit on each keeps the terminal compare clear of any wrap.
  localparam int SLOT_W = $clog2(WAIT_CYC + 1) + 1;
  localparam int POLL_W = $clog2(POLL_MAX + 1) + 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(WAIT_CYC);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);
  localparam logic [POLL_W-1:0] POLL_IGN  = POLL_W'(2);
  localparam logic [8:0]        IDX_LAST  = 9'(N_WORDS - 1);

  // Right-shift Galois taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  logic [2:0]        estado;
  logic [1:0]        modo_q;
  logic [31:0]       semilla_q;
  logic [31:0]       lfsr_q;
  logic [8:0]        idx_q;
  logic [SLOT_W-1:0] slot_q;
  logic [POLL_W-1:0] poll_q;
  logic [15:0]       cuenta_q;
  logic [7:0]        dir_q;
  logic              timeout_q;

  logic              slot_fin;
  logic              ultimo;
  logic [31:0]       esperado;
  logic [31:0]       semilla_ef;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    logic [31:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ LFSR_MASK;
    return r;
  endfunction

  function automatic logic [31:0] patron(input logic [1:0] m, input logic [8:0] i,
                                         input logic [31:0] l);
    logic [31:0] r;
    case (m)
      2'b00:   r = {23'd0, i};
      2'b01:   r = l;
      2'b10:   r = 32'd1 << i[4:0];
      default: r = ~{23'd0, i};
    endcase
    return r;
  endfunction

  assign slot_fin   = (slot_q == SLOT_LAST);
  assign ultimo     = (idx_q == IDX_LAST);
  assign esperado   = patron(modo_q, idx_q, lfsr_q);
  assign semilla_ef = (semilla_i == 32'd0) ? 32'd1 : semilla_i;

  // Sequencer: state, slot/poll timing, pattern generator and sticky results
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      estado    <= IDLE;
      modo_q    <= 2'd0;
      semilla_q <= 32'd0;
      lfsr_q    <= 32'd0;
      idx_q     <= 9'd0;
      slot_q    <= '0;
      poll_q    <= '0;
      cuenta_q  <= 16'd0;
      dir_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else if (abortar_i && estado != IDLE) begin
      estado <= IDLE;
      idx_q  <= 9'd0;
      slot_q <= '0;
      poll_q <= '0;
    end else begin
      case (estado)
        IDLE: begin
          if (inicio_i && !abortar_i) begin
            modo_q    <= modo_i;
            semilla_q <= semilla_ef;
            lfsr_q    <= semilla_ef;
            cuenta_q  <= 16'd0;
            dir_q     <= 8'd0;
            timeout_q <= 1'b0;
            idx_q     <= 9'd0;
            slot_q    <= '0;
            estado    <= ESCRIBIR_DATOS;
          end
        end
        ESCRIBIR_DATOS: begin
          if (slot_fin) begin
            slot_q <= '0;
            lfsr_q <= lfsr_next(lfsr_q);
            if (ultimo) begin
              idx_q  <= 9'd0;
              estado <= ESCRIBIR_INSTRUCCION;
            end else begin
              idx_q <= idx_q + 9'd1;
            end
          end else begin
            slot_q <= slot_q + 1'b1;
          end
        end
        ESCRIBIR_INSTRUCCION: begin
          if (slot_fin) begin
            slot_q <= '0;
            poll_q <= '0;
            estado <= ESPERAR;
          end else begin
            slot_q <= slot_q + 1'b1;
          end
        end
        ESPERAR: begin
          if (poll_q >= POLL_IGN && !salida_i[0]) begin
            idx_q  <= 9'd0;
            slot_q <= '0;
            lfsr_q <= semilla_q;
            estado <= LEER_DATOS;
          end else if (poll_q == POLL_LAST) begin
            timeout_q <= 1'b1;
            estado    <= FIN;
          end else begin
            poll_q <= poll_q + 1'b1;
          end
        end
        LEER_DATOS: begin
          if (slot_fin) begin
            if (salida_i != esperado) begin
              if (cuenta_q != 16'hFFFF) cuenta_q <= cuenta_q + 16'd1;
              if (cuenta_q == 16'd0) dir_q <= idx_q[7:0];
            end
            lfsr_q <= lfsr_next(lfsr_q);
            slot_q <= '0;
            if (ultimo) begin
              estado <= FIN;
            end else begin
              idx_q <= idx_q + 9'd1;
            end
          end else begin
            slot_q <= slot_q + 1'b1;
          end
        end
        FIN: begin
          idx_q  <= 9'd0;
          slot_q <= '0;
          poll_q <= '0;
          estado <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

  // Bus outputs decoded from the state, so an async reset clears them at once
  always_comb begin
    wr_o      = 1'b0;
    reg_sel_o = 1'b0;
    entrada_o = 32'd0;
    addr_o    = 32'd0;
    case (estado)
      ESCRIBIR_DATOS: begin
        wr_o      = 1'b1;
        reg_sel_o = 1'b1;
        addr_o    = {23'd0, idx_q};
        entrada_o = esperado;
      end
      ESCRIBIR_INSTRUCCION: begin
        wr_o      = 1'b1;
        entrada_o = CTRL_WORD;
      end
      LEER_DATOS: begin
        reg_sel_o = 1'b1;
        addr_o    = {23'd0, idx_q};
      end
      default: ;
    endcase
  end

  assign ocupado_o    = (estado != IDLE);
  assign listo_o      = (estado == FIN) && !abortar_i;
  assign timeout_o    = timeout_q;
  assign cuenta_err_o = cuenta_q;
  assign dir_err_o    = dir_q;

endmodule

// File: doc/generador_prueba_spi.md
GENERADOR_PRUEBA_SPI -- requirements
Module: generador_prueba_spi

Interface
REQ-001 SHALL have parameter N_WORDS, default 256, number of words written then read back (legal 2..256).
REQ-002 SHALL have parameter WAIT_CYC, default 10, extra hold cycles per access slot (slot = WAIT_CYC+1 cycles, legal 1..1023).
REQ-003 SHALL have parameter POLL_MAX, default 1000000, status-poll timeout in cycles.
REQ-004 SHALL have parameter CTRL_WORD, default 32'h0000_0FD1, instruction word written to the control register.
REQ-005 SHALL have ports: clk_i in 1, sole clock; reset_i in 1, asynchronous active-high reset.
REQ-006 SHALL have ports: inicio_i in 1, start request; abortar_i in 1, abort request; modo_i in 2, pattern select; semilla_i in 32, LFSR seed.
REQ-007 SHALL have ports: salida_i in 32, peripheral read data and status (bit 0 = busy).
REQ-008 SHALL have ports: wr_o out 1, write strobe; reg_sel_o out 1, 1 = data bank, 0 = control register; entrada_o out 32, write data; addr_o out 32, word address, upper bits zero.
REQ-009 SHALL have ports: ocupado_o out 1, sequence active; listo_o out 1, one-cycle completion pulse; timeout_o out 1, sticky; cuenta_err_o out 16, saturating mismatch count; dir_err_o out 8, address of first mismatch.

Function
REQ-010 SHALL implement states IDLE, ESCRIBIR_DATOS, ESCRIBIR_INSTRUCCION, ESPERAR, LEER_DATOS, FIN.
REQ-011 IDLE: wr_o=0, reg_sel_o=0, entrada_o=0, addr_o=0, ocupado_o=0; inicio_i=1 latches modo_i and semilla_i, clears cuenta_err_o, dir_err_o and timeout_o, and enters ESCRIBIR_DATOS next cycle.
REQ-012 inicio_i SHALL be ignored outside IDLE.
REQ-013 ocupado_o SHALL be 1 in every state except IDLE.
REQ-014 ESCRIBIR_DATOS: wr_o=1, reg_sel_o=1; index i=0..N_WORDS-1; addr_o=i and entrada_o=P(i) from the first cycle of slot i, both held stable for the full slot.
REQ-015 After slot N_WORDS-1, ESCRIBIR_DATOS SHALL go to ESCRIBIR_INSTRUCCION; there is no idle cycle between consecutive slots.
REQ-016 Pattern P(i) by latched mode: 00 = i; 01 = LFSR value; 10 = 1 << (i mod 32); 11 = ~i (32-bit).
REQ-017 LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1; P(0) = seed; one advance per slot; a seed of 0 SHALL be replaced by 32'h1.
REQ-018 ESCRIBIR_INSTRUCCION: wr_o=1, reg_sel_o=0, addr_o=0, entrada_o=CTRL_WORD for one slot; then go to ESPERAR.
REQ-019 ESPERAR: wr_o=0, reg_sel_o=0; salida_i[0] SHALL be ignored for the first 2 cycles.
REQ-020 ESPERAR: from cycle 3 on, salida_i[0]=0 goes to LEER_DATOS with i=0 and the LFSR reloaded from the latched seed.
REQ-021 ESPERAR: if salida_i[0] is still 1 after POLL_MAX cycles, timeout_o=1 and the block goes to FIN, skipping the read phase.
REQ-022 LEER_DATOS: wr_o=0, reg_sel_o=1, entrada_o=0; addr_o=i held for one slot.
REQ-023 LEER_DATOS: salida_i SHALL be sampled on the last cycle of each slot and compared with the regenerated P(i).
REQ-024 On a mismatch, cuenta_err_o SHALL increment, saturating at 16'hFFFF; dir_err_o SHALL capture i only on the first mismatch of a run.
REQ-025 After slot N_WORDS-1 of LEER_DATOS, the block SHALL go to FIN.
REQ-026 FIN: listo_o=1 for exactly one cycle; outputs as in IDLE except sticky results; next state IDLE.
REQ-027 abortar_i=1 in any state except IDLE SHALL force IDLE on the next edge with all strobes 0, without a listo_o pulse; sticky results hold their current values.
REQ-028 If abortar_i and inicio_i are both 1 in IDLE, abort wins and the run does not start.
REQ-029 Sticky results SHALL remain unchanged until the next accepted inicio_i.
REQ-030 Slot and poll counters SHALL be wide enough for WAIT_CYC and POLL_MAX, with no wrap inside a phase.

Reset
REQ-031 reset_i=1 SHALL immediately, asynchronously, force IDLE and all outputs, counters, latched mode, seed and LFSR to 0.
REQ-032 Reset asserted mid-sequence SHALL abandon the run with no listo_o pulse.
REQ-033 After reset deasserts, the first accepted inicio_i SHALL start a clean run.

Verification
REQ-034 N_WORDS=4, WAIT_CYC=2, mode 00, memory model echoes writes, busy clears 5 cycles after the instruction -> data writes addr 0..3 / data 0..3 at 3 cycles each, CTRL_WORD 0xFD1 written, reads 0..3, cuenta_err_o=0, listo_o pulses once.
REQ-035 Mode 01, seed 0 -> first data word 0x00000001; readback with the word at addr 2 corrupted -> cuenta_err_o=1, dir_err_o=2.
REQ-036 salida_i[0] stuck at 1 with POLL_MAX=50 -> timeout_o=1 after 50 ESPERAR cycles, no reg_sel_o=1 read slots, listo_o pulses, cuenta_err_o=0.
REQ-037 abortar_i during data slot 2 -> next cycle wr_o=0, ocupado_o=0, no listo_o; a following inicio_i restarts from addr 0.
REQ-038 reset_i asserted between clock edges during LEER_DATOS -> outputs 0 before the next edge; inicio_i pulsed while ocupado_o=1 has no effect.
REQ-039 Mode 10, N_WORDS=40 -> addr 33 carries data 0x00000002; mode 11 -> addr 5 carries data 0xFFFFFFFA.
